// File: rtl/game_pkg.sv
// Shared types and constants for the dragon-game round sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_PLAY  = 2'd1,
        PH_OVER  = 2'd2,
        PH_PAUSE = 2'd3
    } phase_e;

    localparam int TIME_W          = 7;
    localparam int DEF_ROUND_SEC   = 60;
    localparam int DEF_RESPAWN_SEC = 2;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Control/status bundle between the game sequencer and its surroundings.
// The pause pulse exists only when GAME_PAUSE_EN is defined.
interface game_flow_ctrl_if #(
    parameter int N_DRAGON = 3,
    parameter int SCORE_W  = 10
);
    import game_pkg::*;

    logic                tick_1hz;
    logic                start;
    logic [N_DRAGON-1:0] hit;
`ifdef GAME_PAUSE_EN
    logic                pause;
`endif
    phase_e              phase;
    logic                play_en;
    logic [N_DRAGON-1:0] dragon_en;
    logic [SCORE_W-1:0]  score;
    logic [TIME_W-1:0]   time_left;
    logic                game_over;

    modport master (
`ifdef GAME_PAUSE_EN
        output pause,
`endif
        output tick_1hz, start, hit,
        input  phase, play_en, dragon_en, score, time_left, game_over
    );

    modport slave (
`ifdef GAME_PAUSE_EN
        input  pause,
`endif
        input  tick_1hz, start, hit,
        output phase, play_en, dragon_en, score, time_left, game_over
    );

endinterface

// File: rtl/respawn_timer.sv
// Per-dragon alive flag plus respawn countdown in seconds.
// clear revives the dragon; run low (round not active) kills it.
module respawn_timer #(
    parameter int RESPAWN_SEC = game_pkg::DEF_RESPAWN_SEC,
    parameter int CNT_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             tick_i,
    input  logic             run_i,
    input  logic             clear_i,
    output logic             alive_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             alive_q, alive_d;

    // NOTE: every target gets a default before any branch, otherwise
    // the unassigned paths would infer latches.
    always_comb begin
        count_d = count_q;
        alive_d = alive_q;
        if (clear_i) begin
            count_d = '0;
            alive_d = 1'b1;
        end else if (!run_i) begin
            alive_d = 1'b0;
        end else if (load_i) begin
            count_d = CNT_W'(RESPAWN_SEC);
            alive_d = 1'b0;
        end else if (tick_i && count_q != '0) begin
            count_d = count_q - 1'b1;
            alive_d = (count_q == CNT_W'(1));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            alive_q <= 1'b0;
        end else begin
            count_q <= count_d;
            alive_q <= alive_d;
        end
    end

    assign alive_o = alive_q;
    assign count_o = count_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Round sequencer: phase FSM, round countdown, saturating score, respawn timers.
// Optional pause support is enabled with `define GAME_PAUSE_EN.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int N_DRAGON    = 3,
    parameter int ROUND_SEC   = DEF_ROUND_SEC,
    parameter int RESPAWN_SEC = DEF_RESPAWN_SEC,
    parameter int SCORE_W     = 10
) (
    input logic              clk,
    input logic              rst,
    game_flow_ctrl_if.slave  bus
);

    localparam int CNT_W     = $clog2(RESPAWN_SEC + 1);
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    phase_e              phase_q, phase_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                play_en_q;
    logic                over_q, over_d;
    logic                reload;
    logic                tick_play;
    logic                run;
    logic [N_DRAGON-1:0] hit_acc;
    logic [N_DRAGON-1:0] alive;
    logic [CNT_W-1:0]    resp_cnt [N_DRAGON];
    int                  sum;

    always_comb begin
        phase_d   = phase_q;
        time_d    = time_q;
        score_d   = score_q;
        over_d    = 1'b0;
        reload    = 1'b0;
        tick_play = 1'b0;
        hit_acc   = '0;
        sum       = 0;
        unique case (phase_q)
            PH_IDLE, PH_OVER: begin
                if (bus.start) begin
                    phase_d = PH_PLAY;
                    score_d = '0;
                    time_d  = TIME_W'(ROUND_SEC);
                    reload  = 1'b1;
                end
            end
            PH_PLAY: begin
                // Only live dragons can be struck; the rest are ignored.
                hit_acc = bus.hit & alive;
                sum     = int'(score_q);
                for (int i = 0; i < N_DRAGON; i++) sum = sum + int'(hit_acc[i]);
                score_d = (sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
                if (bus.tick_1hz) begin
                    tick_play = 1'b1;
                    if (time_q == TIME_W'(1)) begin
                        phase_d = PH_OVER;
                        time_d  = '0;
                        over_d  = 1'b1;
                    end else begin
                        time_d = time_q - 1'b1;
                    end
                end
`ifdef GAME_PAUSE_EN
                if (bus.pause && phase_d == PH_PLAY) phase_d = PH_PAUSE;
`endif
            end
`ifdef GAME_PAUSE_EN
            PH_PAUSE: begin
                if (bus.pause) phase_d = PH_PLAY;
            end
`endif
            default: ;
        endcase
    end

    // Timers keep their dragons alive only while a round is in progress.
    assign run = (phase_d == PH_PLAY) || (phase_d == PH_PAUSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_IDLE;
            time_q    <= TIME_W'(ROUND_SEC);
            score_q   <= '0;
            play_en_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            time_q    <= time_d;
            score_q   <= score_d;
            play_en_q <= (phase_d == PH_PLAY);
            over_q    <= over_d;
        end
    end

    for (genvar g = 0; g < N_DRAGON; g++) begin : g_dragon
        respawn_timer #(
            .RESPAWN_SEC (RESPAWN_SEC),
            .CNT_W       (CNT_W)
        ) u_timer (
            .clk     (clk),
            .rst     (rst),
            .load_i  (hit_acc[g]),
            .tick_i  (tick_play),
            .run_i   (run),
            .clear_i (reload),
            .alive_o (alive[g]),
            .count_o (resp_cnt[g])
        );

        a_alive_idle_cnt: assert property (@(posedge clk) disable iff (rst)
            alive[g] |-> resp_cnt[g] == '0);
    end

    assign bus.phase     = phase_q;
    assign bus.play_en   = play_en_q;
    assign bus.dragon_en = alive;
    assign bus.score     = score_q;
    assign bus.time_left = time_q;
    assign bus.game_over = over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus random
// stimulus compared every cycle against a per-dragon array reference model.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int N       = 3;
    localparam int ROUND   = 60;
    localparam int RESPAWN = 2;
    localparam int SW      = 6;
    localparam int SMAX    = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_flow_ctrl_if #(.N_DRAGON(N), .SCORE_W(SW)) bus ();

    game_flow_ctrl #(
        .N_DRAGON    (N),
        .ROUND_SEC   (ROUND),
        .RESPAWN_SEC (RESPAWN),
        .SCORE_W     (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks   = 0;
    int n_failures = 0;

    // Reference model state
    int m_phase, m_score, m_time, m_over;
    int m_en  [N];
    int m_cnt [N];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit st, input bit tk, input logic [N-1:0] h,
                              input bit ps, input bit r);
        int acc;
        if (r) begin
            m_phase = 0; m_score = 0; m_time = ROUND; m_over = 0;
            for (int i = 0; i < N; i++) begin m_en[i] = 0; m_cnt[i] = 0; end
            return;
        end
        m_over = 0;
        case (m_phase)
            0, 2: if (st) begin
                m_phase = 1; m_score = 0; m_time = ROUND;
                for (int i = 0; i < N; i++) begin m_en[i] = 1; m_cnt[i] = 0; end
            end
            1: begin
                acc = 0;
                for (int i = 0; i < N; i++) begin
                    if (h[i] && m_en[i] == 1) begin
                        m_en[i] = 0; m_cnt[i] = RESPAWN; acc++;
                    end else if (tk && m_cnt[i] > 0) begin
                        m_cnt[i]--;
                        if (m_cnt[i] == 0) m_en[i] = 1;
                    end
                end
                m_score = (m_score + acc > SMAX) ? SMAX : m_score + acc;
                if (tk) begin
                    if (m_time == 1) begin
                        m_phase = 2; m_time = 0; m_over = 1;
                        for (int i = 0; i < N; i++) m_en[i] = 0;
                    end else begin
                        m_time--;
                    end
                end
`ifdef GAME_PAUSE_EN
                if (ps && m_phase == 1) m_phase = 3;
`endif
            end
`ifdef GAME_PAUSE_EN
            3: if (ps) m_phase = 1;
`endif
            default: ;
        endcase
        if (ps) acc = 0;
    endtask

    function automatic int model_en_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_en[i] == 1) v |= (1 << i);
        return v;
    endfunction

    task automatic step(input bit st, input bit tk, input logic [N-1:0] h,
                        input bit ps, input bit r);
        @(negedge clk);
        rst          = r;
        bus.start    = st;
        bus.tick_1hz = tk;
        bus.hit      = h;
`ifdef GAME_PAUSE_EN
        bus.pause    = ps;
`endif
        @(posedge clk);
        #1;
        model_step(st, tk, h, ps, r);
        check("phase",     int'(bus.phase),     m_phase);
        check("play_en",   int'(bus.play_en),   (m_phase == 1) ? 1 : 0);
        check("dragon_en", int'(bus.dragon_en), model_en_vec());
        check("score",     int'(bus.score),     m_score);
        check("time_left", int'(bus.time_left), m_time);
        check("game_over", int'(bus.game_over), m_over);
    endtask

    initial begin
        int base;
        bus.start = 1'b0; bus.tick_1hz = 1'b0; bus.hit = '0;
`ifdef GAME_PAUSE_EN
        bus.pause = 1'b0;
`endif
        model_step(0, 0, '0, 0, 1);

        // Reset values
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        check("rst_phase", int'(bus.phase), 0);
        check("rst_time",  int'(bus.time_left), ROUND);
        check("rst_en",    int'(bus.dragon_en), 0);

        // Start a round
        step(1, 0, '0, 0, 0);
        check("start_phase", int'(bus.phase), 1);
        check("start_en",    int'(bus.dragon_en), 3'b111);
        check("start_time",  int'(bus.time_left), 60);
        check("start_score", int'(bus.score), 0);

        // Hits, repeat hit on dead dragon, hit on respawn tick
        step(0, 0, 3'b101, 0, 0);
        check("hit_score", int'(bus.score), 2);
        check("hit_en",    int'(bus.dragon_en), 3'b010);
        step(0, 0, 3'b001, 0, 0);
        check("rehit_score", int'(bus.score), 2);
        step(0, 1, '0, 0, 0);
        step(0, 1, 3'b101, 0, 0);
        check("respawn_en",    int'(bus.dragon_en), 3'b111);
        check("respawn_score", int'(bus.score), 2);

        // start in PLAY is ignored
        step(1, 0, '0, 0, 0);
        check("start_in_play", int'(bus.time_left), 58);

        // Run out the clock; final tick coincides with a hit
        for (int i = 0; i < 57; i++) step(0, 1, '0, 0, 0);
        check("time_one", int'(bus.time_left), 1);
        step(0, 1, 3'b001, 0, 0);
        check("final_phase", int'(bus.phase), 2);
        check("final_score", int'(bus.score), 3);
        check("final_time",  int'(bus.time_left), 0);
        check("final_over",  int'(bus.game_over), 1);
        check("final_en",    int'(bus.dragon_en), 0);
        step(0, 0, 3'b111, 0, 0);
        check("over_pulse", int'(bus.game_over), 0);
        check("over_hold",  int'(bus.score), 3);

        // Restart clears score, then drive score to saturation
        step(1, 0, '0, 0, 0);
        check("restart_score", int'(bus.score), 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 3'b111, 0, 0);
            step(0, 1, '0, 0, 0);
            step(0, 1, '0, 0, 0);
        end
        check("pre_sat", int'(bus.score), 60);
        step(0, 0, 3'b011, 0, 0);
        step(0, 1, '0, 0, 0);
        step(0, 1, '0, 0, 0);
        check("sat_62", int'(bus.score), 62);
        step(0, 0, 3'b111, 0, 0);
        check("sat_max", int'(bus.score), SMAX);

`ifdef GAME_PAUSE_EN
        step(0, 0, '0, 1, 0);
        check("pause_phase", int'(bus.phase), 3);
        base = int'(bus.time_left);
        for (int i = 0; i < 5; i++) step(0, 1, 3'b111, 0, 0);
        check("pause_time",  int'(bus.time_left), base);
        check("pause_score", int'(bus.score), SMAX);
        step(0, 0, '0, 1, 0);
        check("resume_phase", int'(bus.phase), 1);
`endif

        // Mid-round reset
        step(0, 1, 3'b010, 0, 1);
        check("midrst_phase", int'(bus.phase), 0);
        check("midrst_score", int'(bus.score), 0);
        check("midrst_time",  int'(bus.time_left), ROUND);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bit st, tk, ps, r;
            logic [N-1:0] h;
            st = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            ps = ($urandom_range(0, 29) == 0);
            r  = ($urandom_range(0, 999) == 0);
            step(st, tk, h, ps, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Round sequencer for the dragon-shooting game. Owns game phase (idle / play / over), the round countdown, the score accumulator and per-dragon respawn scheduling. Consumes the 1 Hz tick, keyboard start pulse and dragon hit events. Drives the enables that gate dragon motion and display, plus the score and time values shown on screen.

## Interface
- `N_DRAGON`, default 3: number of dragons / hit inputs.
- `ROUND_SEC`, default 60: round length in seconds.
- `RESPAWN_SEC`, default 2: seconds a hit dragon stays disabled.
- `SCORE_W`, default 10: score width.
- `clk` in 1: system clock; one clock for the whole block.
- `rst` in 1: reset, synchronous, active-high.
- `tick_1hz` in 1: one-`clk`-cycle pulse once per second.
- `start` in 1: one-cycle pulse from the keyboard decoder.
- `hit` in N_DRAGON: one-cycle pulse per dragon struck by the missile.
- `pause` in 1: one-cycle toggle pulse. Present only with `GAME_PAUSE_EN`.
- `phase` out 2: 0 IDLE, 1 PLAY, 2 OVER, 3 PAUSE.
- `play_en` out 1: high in PLAY only.
- `dragon_en` out N_DRAGON: dragon alive and active.
- `score` out SCORE_W: accumulated score.
- `time_left` out 7: seconds remaining.
- `game_over` out 1: one-cycle pulse on entry to OVER.

## Operation
- Reset values:
  - `phase` = IDLE
  - `play_en` = 0
  - `dragon_en` = 0
  - `score` = 0
  - `time_left` = ROUND_SEC
  - `game_over` = 0
  - all respawn counters = 0
- IDLE, `start` → PLAY:
  - `score` ← 0
  - `time_left` ← ROUND_SEC
  - `dragon_en` ← all ones
  - respawn counters ← 0
- PLAY, `tick_1hz`:
  - `time_left` decrements.
  - If `time_left` == 1 at the tick: → OVER, `time_left` ← 0, `game_over` pulses, `dragon_en` ← 0.
- OVER, `start` → PLAY with the same reload as from IDLE. `score` holds in OVER until that restart.
- Hit handling (PLAY only):
  - For each i with `hit[i]` && `dragon_en[i]`: `dragon_en[i]` ← 0, respawn counter i ← RESPAWN_SEC.
  - `score` += popcount of accepted hits (0..N_DRAGON).
  - `score` saturates at 2^SCORE_W−1.
  - Hits on disabled dragons, or outside PLAY, are ignored.
- Respawn (PLAY only): on `tick_1hz`, each non-zero counter decrements. A counter reaching 0 sets `dragon_en[i]` ← 1 in the same cycle.
- `start` in PLAY is ignored.
- `start` and `tick_1hz` are evaluated together with phase-priority: the transition decision uses the current `phase`.

## Timing
- All outputs are registered. An input pulse in cycle n is visible at the outputs in cycle n+1.
- `game_over` is high for exactly one cycle.
- A final `tick_1hz` and a `hit` in the same cycle: the hit is scored, then OVER is entered. Both are visible in n+1.
- A `hit[i]` coinciding with the tick that would respawn dragon i: the dragon is still disabled, so the hit is ignored and respawn proceeds.
- `rst` in mid-round overrides everything on the next edge and returns the block to the reset values.
- Respawn latency: RESPAWN_SEC ticks after the accepting cycle. The first tick may arrive 1 cycle to 1 s after the hit.

## Configuration
- `GAME_PAUSE_EN`:
  - Defined: `pause` port exists.
    - PLAY + `pause` → PAUSE.
    - PAUSE + `pause` → PLAY.
    - In PAUSE: `play_en` = 0, `dragon_en` holds, ticks and hits are ignored, counters freeze.
    - `start` in PAUSE is ignored.
  - Undefined: no `pause` port, and `phase` never equals 3.

## Structure
- `game_pkg` holds:
  - phase enum constants (IDLE/PLAY/OVER/PAUSE)
  - `TIME_W` = 7
  - default `ROUND_SEC` and `RESPAWN_SEC`
- One sub-module, `respawn_timer`, instantiated N_DRAGON times:
  - Inputs: load (accepted hit), tick, run, clear.
  - Outputs: alive bit and counter.
- FSM, round timer and saturating score adder live in the top of `game_flow_ctrl`.

## Test plan
- Reset, then `start` → cycle+1: phase=1, `dragon_en`=3'b111, `time_left`=60, `score`=0.
- 60 ticks in PLAY → after the 60th: phase=2, `time_left`=0, `game_over` high exactly 1 cycle, `dragon_en`=0.
- `hit`=3'b101 in PLAY → `score`+2, `dragon_en`=3'b010. A repeat `hit[0]` is ignored. After 2 ticks, `dragon_en`=3'b111.
- Saturation: force `score`=1022, then `hit`=3'b111 → `score`=1023.
- `hit`=3'b001 on the same cycle as the final tick → `score`+1 and phase=2 in the same next cycle. A later `start` clears `score` to 0.
- With `GAME_PAUSE_EN`: `pause`, then 5 ticks and `hit`=3'b111 → `time_left` and `score` unchanged, phase=3. A second `pause` → phase=1.
